// File: rtl/barrel_shift_arbiter_pkg.sv
// Shared definitions for the barrel-shift arbiter: datapath widths, FSM
// state type and the rotate wrap-around helper used when BSA_ROTATE_EN is set.
package bsa_pkg;

  localparam int DATA_W = 16;
  localparam int AMT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits shifted out of the top re-enter at the bottom: data >> (DATA_W - amt).
  // amt = 0 gives a full-width right shift, i.e. zero, so rotate-by-0 is a pass.
  function automatic logic [DATA_W-1:0] rotate_fill(input logic [DATA_W-1:0] data,
                                                    input logic [AMT_W-1:0]  amt);
    logic [AMT_W:0] rsh;
    rsh = (AMT_W+1)'(DATA_W) - {1'b0, amt};
    return data >> rsh;
  endfunction

endpackage

// File: rtl/barrel_shift_arbiter_shifter.sv
// Combinational 16-bit logical left barrel shifter: Q = D << s, zero fill.
// Four binary-weighted stages (1, 2, 4, 8).
module left_barrel_shifter_16bits
  import bsa_pkg::*;
(
  input  logic [DATA_W-1:0] D,
  input  logic [AMT_W-1:0]  s,
  output logic [DATA_W-1:0] Q
);

  logic [DATA_W-1:0] st1, st2, st3;

  // Each stage shifts by its binary weight when the matching amount bit is set.
  always_comb begin
    st1 = s[0] ? {D[DATA_W-2:0],   1'b0}  : D;
    st2 = s[1] ? {st1[DATA_W-3:0], 2'b0}  : st1;
    st3 = s[2] ? {st2[DATA_W-5:0], 4'b0}  : st2;
    Q   = s[3] ? {st3[DATA_W-9:0], 8'b0}  : st3;
  end

endmodule

// File: rtl/barrel_shift_arbiter.sv
// Two-requester arbiter in front of a registered 16-bit left barrel shifter.
// IDLE grants one request (round-robin or fixed priority via RR_EN), BUSY
// registers the shifted result, DONE holds it until the consumer takes it.
// Optional macro BSA_ROTATE_EN adds in_rot0/in_rot1 and rotate support.
module barrel_shift_arbiter
  import bsa_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid0,
  input  logic              in_valid1,
  output logic              in_ready0,
  output logic              in_ready1,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [AMT_W-1:0]  in_amt0,
  input  logic [AMT_W-1:0]  in_amt1,
`ifdef BSA_ROTATE_EN
  input  logic              in_rot0,
  input  logic              in_rot1,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_id
);

  state_t            state;
  logic              last_grant;
  logic [DATA_W-1:0] op_data;
  logic [AMT_W-1:0]  op_amt;
  logic              op_id;
  logic              grant;
  logic              gnt_id;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] result;
`ifdef BSA_ROTATE_EN
  logic              op_rot;
`endif

  left_barrel_shifter_16bits u_shifter (
    .D (op_data),
    .s (op_amt),
    .Q (shift_q)
  );

`ifdef BSA_ROTATE_EN
  assign result = shift_q | (op_rot ? rotate_fill(op_data, op_amt) : '0);
`else
  assign result = shift_q;
`endif

  // Grant decision: only in IDLE; ties go to the requester not served last
  // (round-robin) or always to requester 0 (fixed priority).
  always_comb begin
    grant  = 1'b0;
    gnt_id = 1'b0;
    if (state == IDLE) begin
      if (in_valid0 && in_valid1) begin
        grant  = 1'b1;
        gnt_id = (RR_EN != 0) ? ~last_grant : 1'b0;
      end else if (in_valid0) begin
        grant  = 1'b1;
        gnt_id = 1'b0;
      end else if (in_valid1) begin
        grant  = 1'b1;
        gnt_id = 1'b1;
      end
    end
  end

  assign in_ready0 = grant && !gnt_id;
  assign in_ready1 = grant &&  gnt_id;

  // Capture the granted operands, register the result, hold until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_id     <= 1'b0;
      op_data    <= '0;
      op_amt     <= '0;
      op_id      <= 1'b0;
      last_grant <= 1'b1;
`ifdef BSA_ROTATE_EN
      op_rot     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            op_data    <= gnt_id ? in_data1 : in_data0;
            op_amt     <= gnt_id ? in_amt1  : in_amt0;
            op_id      <= gnt_id;
            last_grant <= gnt_id;
`ifdef BSA_ROTATE_EN
            op_rot     <= gnt_id ? in_rot1 : in_rot0;
`endif
            state      <= BUSY;
          end
        end
        BUSY: begin
          out_data  <= result;
          out_id    <= op_id;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Self-checking bench for barrel_shift_arbiter: reset values, tie handling,
// a table of shift vectors, back-pressure hold, reset during DONE, and
// randomized traffic against an arithmetic reference model.
module tb_barrel_shift_arbiter;

  localparam int RR = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        v [2];
  logic [15:0] d [2];
  logic [3:0]  a [2];
  logic        r [2];
  logic        out_ready;
  logic        in_ready0, in_ready1;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_id;

  int n_cmp = 0;
  int n_err = 0;
  bit last_won = 1'b1;

  barrel_shift_arbiter #(.RR_EN(RR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid0 (v[0]),
    .in_valid1 (v[1]),
    .in_ready0 (in_ready0),
    .in_ready1 (in_ready1),
    .in_data0  (d[0]),
    .in_data1  (d[1]),
    .in_amt0   (a[0]),
    .in_amt1   (a[1]),
`ifdef BSA_ROTATE_EN
    .in_rot0   (r[0]),
    .in_rot1   (r[1]),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  amt;
    logic        rot;
    int          req;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: who wins given the current requests and who was served last.
  function automatic int ref_pick();
    if (v[0] && v[1]) return (RR != 0 && last_won == 1'b0) ? 1 : 0;
    else if (v[0])    return 0;
    else              return 1;
  endfunction

  // Reference: left shift as multiplication modulo 2^16; rotate adds the
  // bits that fell off the top (data / 2^(16-amt)).
  function automatic int ref_result(input int data, input int amt, input bit rot);
    int p;
    int res;
    p   = 1 << amt;
    res = (data * p) % 65536;
`ifdef BSA_ROTATE_EN
    if (rot) res = res + data / (65536 / p);
`endif
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction from the IDLE cycle where requests are presented to the
  // IDLE cycle after the result is consumed.
  task automatic run_txn(input string tag, input int id, input int expd,
                         input int hold, input bit poke1);
    #1;
    check({tag, ".rdy0"}, in_ready0, id == 0);
    check({tag, ".rdy1"}, in_ready1, id == 1);
    check({tag, ".idle_valid"}, out_valid, 0);
    tick();
    v[id]    = 1'b0;
    last_won = id[0];
    if (poke1) begin
      v[1] = 1'b1; d[1] = 16'h0F0F; a[1] = 4'd4; r[1] = 1'b0;
    end
    #1;
    check({tag, ".busy_valid"}, out_valid, 0);
    check({tag, ".busy_rdy0"}, in_ready0, 0);
    check({tag, ".busy_rdy1"}, in_ready1, 0);
    tick();
    check({tag, ".valid"}, out_valid, 1);
    check({tag, ".data"}, out_data, expd);
    check({tag, ".id"}, out_id, id);
    for (int k = 0; k < hold; k++) begin
      tick();
      check({tag, ".hold_valid"}, out_valid, 1);
      check({tag, ".hold_data"}, out_data, expd);
      check({tag, ".hold_id"}, out_id, id);
      check({tag, ".hold_rdy0"}, in_ready0, 0);
      check({tag, ".hold_rdy1"}, in_ready1, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".drain_valid"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int id;
    int expd;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; d[i] = '0; a[i] = '0; r[i] = 1'b0;
    end
    out_ready = 1'b0;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.valid", out_valid, 0);
    check("reset.data", out_data, 0);
    check("reset.id", out_id, 0);
    check("reset.rdy0", in_ready0, 0);
    check("reset.rdy1", in_ready1, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("idle_empty.rdy0", in_ready0, 0);
    check("idle_empty.rdy1", in_ready1, 0);

    // Ties after reset: 0 first, then 1, then 0 again.
    v[0] = 1'b1; d[0] = 16'h0011; a[0] = 4'd1;
    v[1] = 1'b1; d[1] = 16'h0022; a[1] = 4'd2;
    run_txn("tie1", 0, 16'h0022, 0, 1'b0);
    run_txn("tie2", 1, 16'h0088, 0, 1'b0);
    v[0] = 1'b1; d[0] = 16'h4000; a[0] = 4'd1;
    v[1] = 1'b1;
    run_txn("tie3", 0, 16'h8000, 0, 1'b0);
    run_txn("tie4", 1, 16'h0088, 0, 1'b0);

    // Single-requester shift vectors.
    tbl.push_back('{16'h00FF, 4'd4,  1'b0, 0, 16'h0FF0});
    tbl.push_back('{16'h0001, 4'd15, 1'b0, 1, 16'h8000});
    tbl.push_back('{16'hCCCC, 4'd0,  1'b0, 0, 16'hCCCC});
    tbl.push_back('{16'hCCCC, 4'd5,  1'b0, 1, 16'h9980});
    tbl.push_back('{16'hFFFF, 4'd8,  1'b0, 0, 16'hFF00});
    tbl.push_back('{16'h8001, 4'd1,  1'b0, 1, 16'h0002});
    tbl.push_back('{16'h1234, 4'd12, 1'b0, 0, 16'h4000});
`ifdef BSA_ROTATE_EN
    tbl.push_back('{16'hCCCC, 4'd5,  1'b1, 0, 16'h9999});
    tbl.push_back('{16'hCCCC, 4'd0,  1'b1, 1, 16'hCCCC});
    tbl.push_back('{16'h8001, 4'd1,  1'b1, 0, 16'h0003});
`endif
    foreach (tbl[i]) begin
      v[tbl[i].req] = 1'b1;
      d[tbl[i].req] = tbl[i].data;
      a[tbl[i].req] = tbl[i].amt;
      r[tbl[i].req] = tbl[i].rot;
      run_txn($sformatf("vec%0d", i), tbl[i].req, tbl[i].exp, 0, 1'b0);
    end

    // Back-pressure: result held 5 cycles while requester 1 waits, then served.
    v[0] = 1'b1; d[0] = 16'hA5A5; a[0] = 4'd3; r[0] = 1'b0;
    run_txn("hold", 0, 16'h2D28, 5, 1'b1);
    run_txn("hold_next", 1, 16'hF0F0, 0, 1'b0);

    // Reset while a result sits in DONE.
    v[0] = 1'b1; d[0] = 16'h1357; a[0] = 4'd2; r[0] = 1'b0;
    #1;
    tick();
    v[0] = 1'b0;
    tick();
    check("rst_done.pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_done.valid", out_valid, 0);
    check("rst_done.data", out_data, 0);
    check("rst_done.id", out_id, 0);
    check("rst_done.rdy0", in_ready0, 0);
    last_won = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("rst_done.idle_valid", out_valid, 0);
    v[0] = 1'b1; d[0] = 16'h0003; a[0] = 4'd4;
    v[1] = 1'b1; d[1] = 16'h00F0; a[1] = 4'd4;
    run_txn("post_rst_tie", 0, 16'h0030, 0, 1'b0);
    run_txn("post_rst_req1", 1, 16'h0F00, 0, 1'b0);

    // Randomized traffic; unserved requests stay pending with their operands.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!v[i] && $urandom_range(1, 0) == 1) begin
          v[i] = 1'b1;
          d[i] = 16'($urandom);
          a[i] = 4'($urandom_range(15, 0));
          r[i] = 1'($urandom_range(1, 0));
        end
      end
      if (!v[0] && !v[1]) begin
        id = int'($urandom_range(1, 0));
        v[id] = 1'b1;
        d[id] = 16'($urandom);
        a[id] = 4'($urandom_range(15, 0));
        r[id] = 1'($urandom_range(1, 0));
      end
      id   = ref_pick();
      expd = ref_result(int'(d[id]), int'(a[id]), r[id]);
      run_txn($sformatf("rand%0d", n), id, expd, int'($urandom_range(2, 0)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
